// File: rtl/pdp1_tape_feeder_pkg.sv
// Shared types and constants for the PDP-1 paper-tape reader emulator.
package pdp1_tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FEED  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } tape_state_e;

    localparam int FEED_HOLE = 9;
    localparam int CH8       = 8;

    // Bits needed to hold (cycles - 1), never less than one.
    function automatic int cnt_width(input int cycles);
        int w;
        w = 1;
        while ((1 << w) < cycles) w++;
        return w;
    endfunction

endpackage

// File: rtl/pdp1_tape_feeder_if.sv
// Host-to-reader byte stream: valid/ready handshake carrying one tape line per transfer.
interface pdp1_tape_feeder_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/pdp1_tape_feeder_fifo.sv
// Synchronous byte FIFO buffering tape lines between the host loader and the reader FSM.
module tape_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push_i,
    input  logic [7:0]                    push_data_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    output logic [7:0]                    pop_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pops only see entries present at the start of the cycle; flush wins over both.
    assign do_push = push_i & (count_q != DEPTH_C) & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/pdp1_tape_feeder.sv
// Paper-tape reader emulator: plays buffered tape lines onto the panel hole[9:1]
// inputs with settled data around every feed-hole pulse.
module pdp1_tape_feeder
    import pdp1_tape_pkg::*;
#(
    parameter int LINE_CYCLES  = 1000,
    parameter int SETUP_CYCLES = 4,
    parameter int FEED_CYCLES  = 8,
    parameter int HOLD_CYCLES  = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pdp1_tape_feeder_if.slave        host,
    input  logic                     flush,
    input  logic                     rcl,
    output logic [9:1]               hole,
    output logic                     busy,
    output logic                     starved,
    output logic [15:0]              lines_read
);

    localparam int TW = cnt_width(LINE_CYCLES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] FEED_LD  = TW'(FEED_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LINE_LD  = TW'(LINE_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SETUP = ST_SETUP;
    localparam logic [2:0] S_FEED  = ST_FEED;
    localparam logic [2:0] S_HOLD  = ST_HOLD;
    localparam logic [2:0] S_GAP   = ST_GAP;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [TW-1:0] per_q, per_d;
    logic [9:1]    hole_q, hole_d;
    logic [15:0]   lines_q, lines_d;
    logic          busy_q, starved_q;

    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          pop, start;

    tape_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (host.in_valid & host.in_ready),
        .push_data_i (host.in_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count)
    );

    assign host.in_ready = (fifo_count < DEPTH_C);
    assign fifo_empty    = (fifo_count == '0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        per_d   = per_q;
        hole_d  = hole_q;
        lines_d = lines_q;
        pop     = 1'b0;
        start   = 1'b0;
        if (per_q != '0) per_d = per_q - TW'(1);

        case (state_q)
            S_IDLE: begin
                hole_d = '0;
                start  = rcl & ~fifo_empty;
            end
            S_SETUP: begin
                if (tmr_q == '0) begin
                    state_d           = S_FEED;
                    tmr_d             = FEED_LD;
                    hole_d[FEED_HOLE] = 1'b1;
                    lines_d           = lines_q + 16'd1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_FEED: begin
                if (tmr_q == '0) begin
                    state_d           = S_HOLD;
                    tmr_d             = HOLD_LD;
                    hole_d[FEED_HOLE] = 1'b0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = S_GAP;
                    hole_d  = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_GAP: begin
                // The clutch is only consulted once the whole line period has elapsed.
                if (per_q == '0) begin
                    if (rcl & ~fifo_empty) start   = 1'b1;
                    else                   state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                hole_d  = '0;
            end
        endcase

        if (start) begin
            pop     = 1'b1;
            state_d = S_SETUP;
            tmr_d   = SETUP_LD;
            per_d   = LINE_LD;
            hole_d  = {1'b0, fifo_head};
        end

        if (flush) begin
            pop     = 1'b0;
            state_d = S_IDLE;
            tmr_d   = '0;
            per_d   = '0;
            hole_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            per_q     <= '0;
            hole_q    <= '0;
            lines_q   <= '0;
            busy_q    <= 1'b0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            per_q     <= per_d;
            hole_q    <= hole_d;
            lines_q   <= lines_d;
            busy_q    <= (state_d != S_IDLE);
            starved_q <= rcl & fifo_empty & (state_q == S_IDLE);
        end
    end

    assign hole       = hole_q;
    assign busy       = busy_q;
    assign starved    = starved_q;
    assign lines_read = lines_q;

endmodule

// File: tb/tb_pdp1_tape_feeder.sv
// Directed bench for the paper-tape feeder using default timing (1000/4/8/4, depth 16).
module tb_pdp1_tape_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        rcl;
    logic [9:1]  hole;
    logic        busy;
    logic        starved;
    logic [15:0] lines_read;

    int checks   = 0;
    int failures = 0;

    pdp1_tape_feeder_if bif ();

    pdp1_tape_feeder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host       (bif),
        .flush      (flush),
        .rcl        (rcl),
        .hole       (hole),
        .busy       (busy),
        .starved    (starved),
        .lines_read (lines_read)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Expected hole pattern i cycles after a line's data first appears.
    function automatic logic [9:1] line_wave(input int i, input logic [7:0] d);
        if (i < 4)       return {1'b0, d};
        else if (i < 12) return {1'b1, d};
        else if (i < 16) return {1'b0, d};
        else             return 9'h000;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic push_byte(input logic [7:0] b);
        int n;
        bif.in_data  = b;
        bif.in_valid = 1'b1;
        n = 0;
        while (bif.in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL push_timeout byte=%h in_ready never rose", b);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n, bad;
        reset_n = 1'b0; flush = 1'b0; rcl = 1'b0;
        bif.in_valid = 1'b0; bif.in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (hole !== 9'h000 || busy !== 1'b0 || starved !== 1'b0 || lines_read !== 16'd0) begin
            failures++;
            $display("FAIL reset_state hole=%h busy=%b starved=%b lines_read=%0d required 000/0/0/0",
                     hole, busy, starved, lines_read);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b required=1", bif.in_ready);
        end
        push_byte(8'h3C);
        rcl = 1'b1;
        n = 0;
        while (hole[9] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (hole !== 9'h13C || lines_read !== 16'd1) begin
            failures++;
            $display("FAIL reset_reach_feed hole=%h lines_read=%0d required 13c/1", hole, lines_read);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (hole !== 9'h000 || lines_read !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midfeed hole=%h lines_read=%0d busy=%b required 000/0/0",
                     hole, lines_read, busy);
        end
        rcl = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (hole !== 9'h000 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || bif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release bad_cycles=%0d in_ready=%b required 0/1", bad, bif.in_ready);
        end
    endtask

    task automatic test_single();
        int bad, busy_bad, first;
        logic [9:1] first_act;
        push_byte(8'h85);
        rcl = 1'b1;
        bad = 0; busy_bad = 0; first = -1; first_act = '0;
        for (int i = 0; i <= 1005; i++) begin
            @(negedge clk);
            if (hole !== line_wave(i, 8'h85)) begin
                if (first < 0) begin first = i; first_act = hole; end
                bad++;
            end
            if (busy !== (i < 1000)) busy_bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_wave bad_cycles=%0d first_at=%0d hole=%h required=%h",
                     bad, first, first_act, line_wave(first, 8'h85));
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL single_busy bad_cycles=%0d required=0", busy_bad);
        end
        checks++;
        if (lines_read !== 16'd1 || starved !== 1'b1) begin
            failures++;
            $display("FAIL single_end lines_read=%0d starved=%b required 1/1", lines_read, starved);
        end
        rcl = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int         rise_idx [3];
        logic [7:0] rise_dat [3];
        int         nrise, busy_bad;
        logic       prev;
        int         exp_idx [3];
        logic [7:0] exp_dat [3];
        exp_idx = '{4, 1004, 2004};
        exp_dat = '{8'h11, 8'h22, 8'h33};
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        rcl = 1'b1;
        nrise = 0; busy_bad = 0; prev = 1'b0;
        for (int i = 0; i <= 3005; i++) begin
            @(negedge clk);
            if (hole[9] === 1'b1 && prev === 1'b0) begin
                if (nrise < 3) begin
                    rise_idx[nrise] = i;
                    rise_dat[nrise] = hole[8:1];
                end
                nrise++;
            end
            prev = hole[9];
            if (busy !== (i < 3000)) busy_bad++;
        end
        checks++;
        if (nrise != 3) begin
            failures++;
            $display("FAIL stream_pulses got=%0d required=3", nrise);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rise_idx[k] != exp_idx[k] || rise_dat[k] !== exp_dat[k]) begin
                    failures++;
                    $display("FAIL stream_line%0d at=%0d data=%h required at=%0d data=%h",
                             k, rise_idx[k], rise_dat[k], exp_idx[k], exp_dat[k]);
                end
            end
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL stream_no_idle busy_bad_cycles=%0d required=0", busy_bad);
        end
        checks++;
        if (lines_read !== 16'd4) begin
            failures++;
            $display("FAIL stream_lines_read got=%0d required=4", lines_read);
        end
        rcl = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clutch();
        int bad, busy_bad;
        push_byte(8'hA1);
        push_byte(8'hB2);
        rcl = 1'b1;
        bad = 0; busy_bad = 0;
        for (int i = 0; i <= 1010; i++) begin
            @(negedge clk);
            if (i == 1) rcl = 1'b0;
            if (hole !== line_wave(i, 8'hA1)) bad++;
            if (busy !== (i < 1000)) busy_bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clutch_line1 bad_cycles=%0d required=0", bad);
        end
        checks++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clutch_busy bad_cycles=%0d busy=%b required 0/0", busy_bad, busy);
        end
        checks++;
        if (lines_read !== 16'd5) begin
            failures++;
            $display("FAIL clutch_lines_read got=%0d required=5", lines_read);
        end
        rcl = 1'b1;
        @(negedge clk);
        checks++;
        if (hole !== 9'h0B2) begin
            failures++;
            $display("FAIL clutch_line2_kept hole=%h required=0b2", hole);
        end
        rcl = 1'b0;
        pulse_flush();
    endtask

    task automatic test_full();
        for (int k = 0; k < 16; k++) push_byte(8'h40 + 8'(k));
        checks++;
        if (bif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready_low in_ready=%b required=0", bif.in_ready);
        end
        bif.in_data  = 8'h5F;
        bif.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_hold_off in_ready=%b required=0", bif.in_ready);
        end
        rcl = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b1 || hole !== 9'h040) begin
            failures++;
            $display("FAIL full_first_pop in_ready=%b hole=%h required 1/040", bif.in_ready, hole);
        end
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_17th_accepted in_ready=%b required=0", bif.in_ready);
        end
        bif.in_valid = 1'b0;
        rcl = 1'b0;
        pulse_flush();
    endtask

    task automatic test_flush();
        int n, bad;
        for (int k = 0; k < 6; k++) push_byte(8'h61 + 8'(k));
        rcl = 1'b1;
        n = 0;
        while (hole[9] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (hole !== 9'h161 || lines_read !== 16'd6) begin
            failures++;
            $display("FAIL flush_in_feed hole=%h lines_read=%0d required 161/6", hole, lines_read);
        end
        flush = 1'b1;
        bif.in_data  = 8'h77;
        bif.in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bif.in_valid = 1'b0;
        checks++;
        if (hole !== 9'h000 || busy !== 1'b0 || lines_read !== 16'd6) begin
            failures++;
            $display("FAIL flush_next_cycle hole=%h busy=%b lines_read=%0d required 000/0/6",
                     hole, busy, lines_read);
        end
        bad = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (hole !== 9'h000 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || lines_read !== 16'd6) begin
            failures++;
            $display("FAIL flush_quiet bad_cycles=%0d lines_read=%0d required 0/6", bad, lines_read);
        end
        checks++;
        if (starved !== 1'b1 || bif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty starved=%b in_ready=%b required 1/1", starved, bif.in_ready);
        end
    endtask

    task automatic test_no_forward();
        push_byte(8'h99);
        checks++;
        if (hole !== 9'h000) begin
            failures++;
            $display("FAIL nofwd_same_cycle hole=%h required=000", hole);
        end
        @(negedge clk);
        checks++;
        if (hole !== 9'h099) begin
            failures++;
            $display("FAIL nofwd_next_cycle hole=%h required=099", hole);
        end
        rcl = 1'b0;
        pulse_flush();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_clutch();
        test_full();
        test_flush();
        test_no_forward();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
